// File: rtl/buscador_pkg.sv
// Shared definitions for the binary-search driver of the magnitude comparator:
// FSM encoding, default operand width and the widened bound width.
package buscador_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        FIN     = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

    // lo/hi carry one extra bit so guess+1 at the top of the range is representable.
    localparam int BOUND_EXTRA = 1;

    function automatic int bound_width(input int w);
        return w + BOUND_EXTRA;
    endfunction

endpackage

// File: rtl/paso_sar.sv
// One binary-search step: resolves the comparator flags and derives the next
// bounds, next midpoint and empty-range condition. BUSCADOR_CHECK_EN enables
// strict one-hot flag checking; otherwise flags resolve as igual > M > m.
module paso_sar
    import buscador_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   lo,
    input  logic [WIDTH:0]   hi,
    input  logic [WIDTH-1:0] guess,
    input  logic             M,
    input  logic             igual,
    input  logic             m,
    output logic             acierto,
    output logic             invalido,
    output logic             vacio,
    output logic [WIDTH:0]   next_lo,
    output logic [WIDTH:0]   next_hi,
    output logic [WIDTH-1:0] next_guess
);

    logic             sube;
    logic             baja;
    logic [WIDTH:0]   g_ext;
    logic [WIDTH+1:0] suma;

    // NOTE: every output gets a default before any branch so no latch is inferred.
    always_comb begin
        g_ext = {1'b0, guess};
`ifdef BUSCADOR_CHECK_EN
        invalido = ~((M ^ igual ^ m) & ~(M & igual & m));
        acierto  = igual & ~invalido;
        sube     = M & ~invalido;
        baja     = m & ~invalido;
`else
        invalido = 1'b0;
        acierto  = igual;
        sube     = ~igual & M;
        baja     = ~igual & ~M;  // all flags low is treated as m
`endif
        next_lo = lo;
        next_hi = hi;
        vacio   = 1'b0;

        if (sube) begin
            next_lo = g_ext + {{WIDTH{1'b0}}, 1'b1};
        end
        if (baja) begin
            // guess-1 below zero is an empty range, never a wrap-around
            if (guess == '0) begin
                vacio = 1'b1;
            end else begin
                next_hi = g_ext - {{WIDTH{1'b0}}, 1'b1};
            end
        end
        if (next_lo > next_hi) begin
            vacio = 1'b1;
        end

        suma       = {1'b0, next_lo} + {1'b0, next_hi};
        next_guess = suma[WIDTH:1];
    end

endmodule

// File: rtl/buscador_sar.sv
// Binary-search driver for a combinational comparator: one probe per clock.
// Flag checking is selected at build time by BUSCADOR_CHECK_EN (see paso_sar).
module buscador_sar
    import buscador_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             M,
    input  logic             igual,
    input  logic             m,
    output logic [WIDTH-1:0] guess,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [WIDTH-1:0] result,
    output logic             error
);

    localparam int BW = bound_width(WIDTH);
    localparam logic [BW-1:0]    HI_INI    = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH-1:0] GUESS_INI = HI_INI[WIDTH:1];

    state_t           state_q, state_d;
    logic [BW-1:0]    lo_q, lo_d;
    logic [BW-1:0]    hi_q, hi_d;
    logic [WIDTH-1:0] guess_q, guess_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             found_q, found_d;
    logic             error_q, error_d;

    logic             acierto;
    logic             invalido;
    logic             vacio;
    logic [BW-1:0]    next_lo;
    logic [BW-1:0]    next_hi;
    logic [WIDTH-1:0] next_guess;

    paso_sar #(.WIDTH(WIDTH)) u_paso (
        .lo        (lo_q),
        .hi        (hi_q),
        .guess     (guess_q),
        .M         (M),
        .igual     (igual),
        .m         (m),
        .acierto   (acierto),
        .invalido  (invalido),
        .vacio     (vacio),
        .next_lo   (next_lo),
        .next_hi   (next_hi),
        .next_guess(next_guess)
    );

    // NOTE: state registers use non-blocking assignments so all update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            lo_q     <= '0;
            hi_q     <= '0;
            guess_q  <= '0;
            result_q <= '0;
            found_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            guess_q  <= guess_d;
            result_q <= result_d;
            found_q  <= found_d;
            error_q  <= error_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        guess_d  = guess_q;
        result_d = result_q;
        found_d  = found_q;
        error_d  = error_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    lo_d     = '0;
                    hi_d     = HI_INI;
                    guess_d  = GUESS_INI;
                    result_d = '0;
                    found_d  = 1'b0;
                    error_d  = 1'b0;
                    state_d  = COMPARE;
                end
            end
            COMPARE: begin
                if (invalido) begin
                    result_d = guess_q;
                    found_d  = 1'b0;
                    error_d  = 1'b1;
                    state_d  = FIN;
                end else if (acierto) begin
                    result_d = guess_q;
                    found_d  = 1'b1;
                    state_d  = FIN;
                end else begin
                    lo_d = next_lo;
                    hi_d = next_hi;
                    if (vacio) begin
                        result_d = guess_q;
                        found_d  = 1'b0;
                        state_d  = FIN;
                    end else begin
                        guess_d = next_guess;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign guess  = guess_q;
    assign busy   = (state_q == COMPARE);
    assign done   = (state_q == FIN);
    assign found  = found_q;
    assign result = result_q;
    assign error  = error_q;

endmodule

// File: tb/tb_buscador_sar.sv
// Directed bench for buscador_sar: behavioural comparator around the DUT,
// hand-computed probe sequences, latencies and final flags.
module tb_buscador_sar;

    localparam int W = 4;

    typedef int gl_t[8];

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         M, igual, m;
    logic [W-1:0] guess;
    logic         busy, done, found, error;
    logic [W-1:0] result;

    int hidden = 0;
    int mode = 0;  // 0: honest comparator, 1: M forced, 2: M and m forced
    int checks = 0;
    int passes = 0;

    buscador_sar #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .M     (M),
        .igual (igual),
        .m     (m),
        .guess (guess),
        .busy  (busy),
        .done  (done),
        .found (found),
        .result(result),
        .error (error)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (mode)
            1:       {M, igual, m} = 3'b100;
            2:       {M, igual, m} = 3'b101;
            default: begin
                M     = hidden > int'(guess);
                igual = hidden == int'(guess);
                m     = hidden < int'(guess);
            end
        endcase
    end

    task automatic run_search(input string name, input int hid, input int md, input gl_t eg,
                              input int n, input int restart_at, input logic ef, input int er,
                              input logic ee);
        int cyc;
        bit seen_done;
        logic         hold_found;
        logic [W-1:0] hold_result;
        hidden = hid;
        mode   = md;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        seen_done = 0;
        while (!seen_done && cyc <= 20) begin
            start = (cyc == restart_at);
            if (done === 1'b1) begin
                seen_done = 1;
                checks++;
                if (cyc !== n + 1) $display("FAIL %s done_cycle got %0d want %0d", name, cyc, n + 1);
                else passes++;
                checks++;
                if (found !== ef) $display("FAIL %s found got %0b want %0b", name, found, ef);
                else passes++;
                checks++;
                if (int'(result) !== er) $display("FAIL %s result got %0d want %0d", name, result, er);
                else passes++;
                checks++;
                if (error !== ee) $display("FAIL %s error got %0b want %0b", name, error, ee);
                else passes++;
            end else begin
                checks++;
                if (busy !== 1'b1) $display("FAIL %s busy@%0d got %0b want 1", name, cyc, busy);
                else passes++;
                checks++;
                if (cyc > n) $display("FAIL %s extra_guess@%0d got %0d want done", name, cyc, guess);
                else if (int'(guess) !== eg[cyc-1])
                    $display("FAIL %s guess@%0d got %0d want %0d", name, cyc, guess, eg[cyc-1]);
                else passes++;
                if (cyc == 1) begin
                    checks++;
                    if ({found, error, result} !== '0)
                        $display("FAIL %s cleared_at_start got f=%0b e=%0b r=%0d want 0/0/0",
                                 name, found, error, result);
                    else passes++;
                end
            end
            hold_found  = found;
            hold_result = result;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        checks++;
        if (!seen_done) begin
            $display("FAIL %s timeout got no done want done within 20 cycles", name);
        end else if (done !== 1'b0 || busy !== 1'b0 || found !== hold_found || result !== hold_result) begin
            $display("FAIL %s after_done got d=%0b b=%0b f=%0b r=%0d want 0/0/%0b/%0d",
                     name, done, busy, found, result, hold_found, hold_result);
        end else passes++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({guess, result, busy, done, found, error} !== '0)
            $display("FAIL reset outputs got g=%0d r=%0d b=%0b d=%0b f=%0b e=%0b want all 0",
                     guess, result, busy, done, found, error);
        else passes++;
        rst = 1'b0;
    endtask

    task automatic test_searches();
        run_search("hidden9",  9,  0, '{7, 11, 9, 0, 0, 0, 0, 0},    3, 0, 1'b1, 9,  1'b0);
        run_search("hidden15", 15, 0, '{7, 11, 13, 14, 15, 0, 0, 0}, 5, 0, 1'b1, 15, 1'b0);
        run_search("hidden0",  0,  0, '{7, 3, 1, 0, 0, 0, 0, 0},     4, 0, 1'b1, 0,  1'b0);
        run_search("hidden4",  4,  0, '{7, 3, 5, 4, 0, 0, 0, 0},     4, 0, 1'b1, 4,  1'b0);
    endtask

    task automatic test_not_found();
        run_search("forced_M", 0, 1, '{7, 11, 13, 14, 15, 0, 0, 0}, 5, 0, 1'b0, 15, 1'b0);
    endtask

    task automatic test_invalid_flags();
`ifdef BUSCADOR_CHECK_EN
        run_search("invalid_Mm", 0, 2, '{7, 0, 0, 0, 0, 0, 0, 0}, 1, 0, 1'b0, 7, 1'b1);
`else
        run_search("invalid_Mm", 0, 2, '{7, 11, 13, 14, 15, 0, 0, 0}, 5, 0, 1'b0, 15, 1'b0);
`endif
    endtask

    task automatic test_start_ignored();
        run_search("restart_busy", 9, 0, '{7, 11, 9, 0, 0, 0, 0, 0}, 3, 2, 1'b1, 9, 1'b0);
        run_search("restart_fin",  9, 0, '{7, 11, 9, 0, 0, 0, 0, 0}, 3, 4, 1'b1, 9, 1'b0);
    endtask

    task automatic test_reset_mid();
        hidden = 9;
        mode   = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (guess !== 4'd11 || busy !== 1'b1)
            $display("FAIL rst_mid second_probe got g=%0d b=%0b want 11/1", guess, busy);
        else passes++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({guess, result, busy, done, found, error} !== '0)
            $display("FAIL rst_mid outputs got g=%0d r=%0d b=%0b d=%0b f=%0b e=%0b want all 0",
                     guess, result, busy, done, found, error);
        else passes++;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0)
                $display("FAIL rst_mid idle@%0d got d=%0b b=%0b want 0/0", i, done, busy);
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_searches();
        test_not_found();
        test_invalid_flags();
        test_start_ignored();
        test_reset_mid();
        run_search("after_rst", 9, 0, '{7, 11, 9, 0, 0, 0, 0, 0}, 3, 0, 1'b1, 9, 1'b0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/buscador_sar.md
# buscador_sar

Sequential counterpart of the team's cascaded magnitude comparators. The comparator consumes two operands and produces the flags M / igual / m. This block consumes those flags and drives one operand to recover the unknown value held on the other side. It runs a binary search, one comparison per clock, and reports the located value. The block sits beside a combinational `Comp`-style comparator: `guess` feeds its `b` input, and the hidden value feeds its `a` input.

## Interface
- `WIDTH`, default 4: width of `guess` and `result`; search range is 0 .. 2^WIDTH-1.
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request a new search; sampled only in IDLE.
- `M`  in  1: comparator flag, hidden value > `guess`.
- `igual`  in  1: comparator flag, hidden value == `guess`.
- `m`  in  1: comparator flag, hidden value < `guess`.
- `guess`  out  WIDTH: registered probe value driven to the comparator.
- `busy`  out  1: high while in COMPARE.
- `done`  out  1: one-cycle pulse at the end of a search.
- `found`  out  1: valid with `done`, held until the next `start`; 1 means `igual` was seen.
- `result`  out  WIDTH: value at the last comparison, held until the next `start`.
- `error`  out  1: invalid flag combination seen; valid with `done`, held until the next `start`.

## Operation
- States: IDLE, COMPARE, FIN. Encoding is in the package.
- Reset: state IDLE, and `guess`, `result` = 0. `busy`, `done`, `found`, `error` = 0.
- IDLE, `start`=1:
  - set lo=0 and hi=2^WIDTH-1.
  - `guess` <= (lo+hi)>>1.
  - clear `found`, `error` and `result`.
  - go to COMPARE.
- IDLE, `start`=0: hold all outputs.
- COMPARE samples the flags each cycle against the current registered `guess`.
  - `igual`: `result`<=`guess`, `found`<=1, go to FIN.
  - `M`: lo<=`guess`+1.
  - `m`: hi<=`guess`-1.
  - After an `M` or `m` update, if new lo > new hi: `result`<=`guess`, `found`<=0, go to FIN. Otherwise load the new midpoint (lo+hi)>>1 into `guess` and stay in COMPARE.
- FIN: `done`=1 for exactly one cycle, then IDLE.
- Width rule: lo and hi are WIDTH+1 bits unsigned. hi=guess-1 with guess=0 is treated as an empty range (lo>hi), never as wrap-around. lo=guess+1 with guess=2^WIDTH-1 yields 2^WIDTH, which is also an empty range.
- Midpoint rounds down.
- `start` while busy or in FIN is ignored.
- `rst` mid-search aborts immediately to the reset values. No `done` pulse is produced.

## Timing
- `start` sampled at edge 0. First `guess` is valid after edge 0 and `busy`=1 from then.
- The comparator is combinational. Flags are sampled at the following edge, so there is 1 clock per comparison.
- A search with k comparisons takes k cycles in COMPARE, and `done` is high in cycle k+1 after `start`.
- Worst case is WIDTH+1 comparisons, giving latency WIDTH+2 cycles from `start` to `done`.
- `found`, `result` and `error` change only at the FIN transition (or at `start`/`rst`) and are stable while `done`=1.

## Configuration
- `BUSCADOR_CHECK_EN` defined:
  - In COMPARE, any flag set that is not exactly one-hot (none, or more than one high) sets `error`=1, `found`=0 and `result`=`guess`, then goes to FIN.
- Not defined:
  - `error` is tied 0.
  - Flags are resolved by priority `igual` > `M` > `m`.
  - All flags low counts as `m`.

## Structure
- Package `buscador_pkg`:
  - state encoding constants IDLE/COMPARE/FIN.
  - default `WIDTH`.
  - midpoint/bound-width helper constants (WIDTH+1).
- One natural sub-module, `paso_sar`: combinational next-lo/next-hi/next-guess/empty-range computation from (lo, hi, guess, flags). The FSM registers its outputs.
- The bench instantiates a behavioural comparator producing M/igual/m from `guess` and a hidden value.

## Test plan
- WIDTH=4, hidden=9, `start` pulse: guesses 7, 11, 9. `done` in cycle 4 with `found`=1, `result`=9, `error`=0.
- Hidden=15: guesses 7, 11, 13, 14, 15 (worst case). `done` in cycle 6, `found`=1, `result`=15.
- Hidden=0: guesses 7, 3, 1, 0. `found`=1 and `result`=0. No underflow of hi.
- Comparator forced to M=1 always: guesses 7, 11, 13, 14, 15, then lo=16>hi. `done` with `found`=0, `result`=15.
- `BUSCADOR_CHECK_EN` defined, M=m=1 on the first comparison: `done` in cycle 2 with `error`=1, `found`=0 and `result`=7. Macro undefined, same stimulus: search proceeds as `M`.
- Hidden=9, `rst` asserted during the second comparison: next cycle in IDLE with all outputs 0 and no `done`. A `start` asserted while busy is ignored; the search result is unchanged.
